mem_io_responder: RTL and testbench

- Responder end of the CPU's byte-wide memory bus (address, write data, write strobe, read data, io_buffer_full).
- Holds the 128KB program/data RAM and decodes the memory-mapped I/O window at 0x30000.
- Connects to a UART receiver (RX FIFO) and a UART transmitter (TX FIFO) through valid/ready handshakes.
- Provides the one-cycle read latency and the I/O semantics the CPU core is built against.

---
 rtl/mem_io_responder_if.sv | 38 +++
 rtl/mem_io_responder.sv | 212 +++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// ---------------------------------------------------------------------------
// mem_io_responder_if
// Groups the CPU byte bus and the two UART valid/ready links that meet at the
// memory/IO responder.
//   master : CPU core plus UART side (drives address/data/strobe, rx byte,
//            tx_ready; observes read data, io_buffer_full, rx_ready, tx link)
//   slave  : the responder itself
// Signals:
//   cpu_a[31:0], cpu_dout[7:0], cpu_wr  : CPU address, write data, 1=write
//   cpu_din[7:0], io_buffer_full        : read data (next cycle), TX near-full
//   rx_valid, rx_data[7:0], rx_ready    : UART receiver into RX FIFO
//   tx_valid, tx_data[7:0], tx_ready    : TX FIFO out to UART transmitter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output cpu_a, cpu_dout, cpu_wr, rx_valid, rx_data, tx_ready,
        input  cpu_din, io_buffer_full, rx_ready, tx_valid, tx_data
    );

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, rx_valid, rx_data, tx_ready,
        output cpu_din, io_buffer_full, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/mem_io_responder.sv
// ---------------------------------------------------------------------------
// mem_io_responder
// Responder end of the CPU byte bus. Holds the program/data RAM, decodes the
// I/O window at 0x30000 (RX FIFO pop, cycle counter, TX FIFO push, stop), and
// bridges to the UART receiver/transmitter through small FIFOs.
// Ports:
//   clk_in        system clock
//   rst_in        asynchronous active-low reset
//   bus           mem_io_responder_if.slave (CPU bus + UART handshakes)
//   program_stop  sticky, set by a write to 0x30004
//   tx_overflow   sticky, a TX push was dropped because the FIFO was full
// Address map on cpu_a[17:16]: 00/01 RAM, 10 unmapped (reads 0x00),
// 11 I/O (offset cpu_a[15:0]).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int RX_DEPTH    = 8,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic                program_stop,
    output logic                tx_overflow
);

    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;

    typedef enum logic [2:0] {
        SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT0, SEL_SNAP1, SEL_SNAP2, SEL_SNAP3
    } rd_sel_t;

    // Bus decode
    logic              cpu_rd, cpu_wr, is_ram, is_io;
    logic [15:0]       io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_cpu_a_hi;

    assign cpu_wr          = bus.cpu_wr;
    assign cpu_rd          = ~bus.cpu_wr;
    assign is_ram          = ~bus.cpu_a[17];
    assign is_io           = &bus.cpu_a[17:16];
    assign io_off          = bus.cpu_a[15:0];
    assign ram_idx         = bus.cpu_a[RAM_AW-1:0];
    assign unused_cpu_a_hi = ^bus.cpu_a[31:18];

    // RAM storage and its read register are deliberately not reset so the
    // array maps onto block RAM and survives a reset.
    logic [7:0] ram [1 << RAM_AW];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (is_ram && cpu_wr) ram[ram_idx] <= bus.cpu_dout;
        if (is_ram && cpu_rd) ram_q <= ram[ram_idx];
    end

    // RX FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]       rx_byte_q;

    assign rx_empty     = (rx_count == '0);
    assign rx_full      = (rx_count == RX_CW'(RX_DEPTH));
    // Held low during reset so no byte is accepted while pointers are cleared.
    assign bus.rx_ready = rst_in & ~rx_full;
    assign rx_push      = bus.rx_valid & bus.rx_ready;
    assign rx_pop       = is_io & cpu_rd & (io_off == 16'h0000) & ~rx_empty;

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
    end

    // TX FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count, tx_count_next, tx_free_next;
    logic             tx_full, tx_req, tx_push, tx_pop, stop_wr;
    logic [7:0]       tx_push_byte;
    logic             io_buffer_full_q;

    assign stop_wr      = is_io & cpu_wr & (io_off == 16'h0004);
    assign tx_req       = stop_wr |
                          (is_io & cpu_wr & (io_off == 16'h0000) & (bus.cpu_dout != 8'h00));
    assign tx_push_byte = stop_wr ? 8'h00 : bus.cpu_dout;
    assign tx_full      = (tx_count == TX_CW'(TX_DEPTH));
    assign bus.tx_valid = (tx_count != '0);
    assign tx_pop       = bus.tx_valid & bus.tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign tx_push      = tx_req & (~tx_full | tx_pop);
    assign bus.tx_data  = bus.tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
    assign tx_free_next = TX_CW'(TX_DEPTH) - tx_count_next;

    assign bus.io_buffer_full = io_buffer_full_q;

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_byte;
    end

    always_comb begin
        tx_count_next = tx_count;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_next = tx_count + TX_CW'(1);
            2'b01:   tx_count_next = tx_count - TX_CW'(1);
            default: tx_count_next = tx_count;
        endcase
    end

    // FIFO pointers/counts, sticky flags and the near-full flag. The flag is
    // registered from the next count so it lines up with the count itself.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wr_ptr        <= '0;
            rx_rd_ptr        <= '0;
            rx_count         <= '0;
            rx_byte_q        <= 8'h00;
            tx_wr_ptr        <= '0;
            tx_rd_ptr        <= '0;
            tx_count         <= '0;
            io_buffer_full_q <= 1'b0;
            program_stop     <= 1'b0;
            tx_overflow      <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
                rx_byte_q <= rx_mem[rx_rd_ptr];
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
            tx_count         <= tx_count_next;
            io_buffer_full_q <= (tx_free_next <= TX_CW'(FULL_MARGIN));
            if (stop_wr) program_stop <= 1'b1;
            if (tx_req && !tx_push) tx_overflow <= 1'b1;
        end
    end

    // Read source select, captured with the address. Write cycles keep the
    // previous select so cpu_din holds the last read result.
    rd_sel_t     rd_sel, rd_sel_next;
    logic [31:0] cycle_cnt;
    logic [7:0]  cnt_lo_q;
    logic [23:0] snapshot;
    logic        cnt_rd;

    assign cnt_rd = is_io & cpu_rd & (io_off == 16'h0004);

    always_comb begin
        rd_sel_next = rd_sel;
        if (cpu_rd) begin
            rd_sel_next = SEL_ZERO;
            if (is_ram) begin
                rd_sel_next = SEL_RAM;
            end else if (is_io) begin
                case (io_off)
                    16'h0000: rd_sel_next = rx_empty ? SEL_ZERO : SEL_RX;
                    16'h0004: rd_sel_next = SEL_CNT0;
                    16'h0005: rd_sel_next = SEL_SNAP1;
                    16'h0006: rd_sel_next = SEL_SNAP2;
                    16'h0007: rd_sel_next = SEL_SNAP3;
                    default:  rd_sel_next = SEL_ZERO;
                endcase
            end
        end
    end

    // Reading byte 0 freezes the upper three bytes so a four-byte read
    // sequence returns one coherent counter value.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_sel    <= SEL_ZERO;
            cycle_cnt <= 32'h0;
            cnt_lo_q  <= 8'h00;
            snapshot  <= 24'h0;
        end else begin
            rd_sel    <= rd_sel_next;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (cnt_rd) begin
                cnt_lo_q <= cycle_cnt[7:0];
                snapshot <= cycle_cnt[31:8];
            end
        end
    end

    // Read data mux
    always_comb begin
        bus.cpu_din = 8'h00;
        case (rd_sel)
            SEL_RAM:   bus.cpu_din = ram_q;
            SEL_RX:    bus.cpu_din = rx_byte_q;
            SEL_CNT0:  bus.cpu_din = cnt_lo_q;
            SEL_SNAP1: bus.cpu_din = snapshot[7:0];
            SEL_SNAP2: bus.cpu_din = snapshot[15:8];
            SEL_SNAP3: bus.cpu_din = snapshot[23:16];
            default:   bus.cpu_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_io_responder
// Directed bench for mem_io_responder: reset values, cycle-counter snapshot,
// RAM read/write, RX FIFO pops, TX FIFO fill/overflow/drain, program stop and
// asynchronous reset in the middle of a read.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_io_responder;

    logic clk_in;
    logic rst_in;
    logic program_stop;
    logic tx_overflow;

    int test_count = 0;
    int fail_count = 0;

    localparam logic [31:0] IDLE_ADDR = 32'h0002_0000;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    // 100 MHz clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Presents one bus transaction and lets it clock in
    task automatic apply_stimulus(input logic [31:0] addr, input logic wr,
                                  input logic [7:0] dout);
        bus.cpu_a    = addr;
        bus.cpu_wr   = wr;
        bus.cpu_dout = dout;
        step();
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_in       = 1'b0;
        bus.cpu_a    = IDLE_ADDR;
        bus.cpu_wr   = 1'b0;
        bus.cpu_dout = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;

        // Reset values
        check_output("rst_cpu_din",      32'(bus.cpu_din),        32'h00);
        check_output("rst_io_full",      32'(bus.io_buffer_full), 32'h0);
        check_output("rst_rx_ready",     32'(bus.rx_ready),       32'h0);
        check_output("rst_tx_valid",     32'(bus.tx_valid),       32'h0);
        check_output("rst_tx_data",      32'(bus.tx_data),        32'h00);
        check_output("rst_program_stop", 32'(program_stop),       32'h0);
        check_output("rst_tx_overflow",  32'(tx_overflow),        32'h0);

        // Counter is 0 during the first cycle after release; 255 idle cycles
        // later the 0x30004 read samples 0x000000FF.
        rst_in = 1'b1;
        for (int i = 0; i < 255; i++) apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        check_output("rx_ready_after_rst", 32'(bus.rx_ready), 32'h1);
        apply_stimulus(32'h0003_0004, 1'b0, 8'h00);
        check_output("cnt_byte0", 32'(bus.cpu_din), 32'hFF);
        apply_stimulus(32'h0003_0005, 1'b0, 8'h00);
        check_output("cnt_byte1", 32'(bus.cpu_din), 32'h00);
        apply_stimulus(32'h0003_0006, 1'b0, 8'h00);
        check_output("cnt_byte2", 32'(bus.cpu_din), 32'h00);
        apply_stimulus(32'h0003_0007, 1'b0, 8'h00);
        check_output("cnt_byte3", 32'(bus.cpu_din), 32'h00);

        // RAM read/write
        apply_stimulus(32'h0001_FFFF, 1'b1, 8'h3C);
        apply_stimulus(32'h0001_FFFF, 1'b0, 8'h00);
        check_output("ram_top", 32'(bus.cpu_din), 32'h3C);
        apply_stimulus(32'h0000_0010, 1'b1, 8'hA5);
        check_output("wr_holds_din", 32'(bus.cpu_din), 32'h3C);
        apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
        check_output("ram_0x10", 32'(bus.cpu_din), 32'hA5);
        apply_stimulus(32'h0002_0010, 1'b1, 8'h77);
        apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
        check_output("unmapped_wr_no_alias", 32'(bus.cpu_din), 32'hA5);
        apply_stimulus(32'h0002_0010, 1'b0, 8'h00);
        check_output("unmapped_rd", 32'(bus.cpu_din), 32'h00);

        // RX FIFO
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h41;
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        bus.rx_data  = 8'h42;
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        bus.rx_valid = 1'b0;
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_pop1", 32'(bus.cpu_din), 32'h41);
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_pop2", 32'(bus.cpu_din), 32'h42);
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_pop_empty", 32'(bus.cpu_din), 32'h00);
        // Push and pop in the same cycle
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h43;
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        bus.rx_data  = 8'h44;
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_pop_push_same", 32'(bus.cpu_din), 32'h43);
        bus.rx_valid = 1'b0;
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_pop_after_both", 32'(bus.cpu_din), 32'h44);
        apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
        check_output("rx_empty_again", 32'(bus.cpu_din), 32'h00);

        // TX fill: five pushes leave 3 free slots, the sixth leaves 2
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus(32'h0003_0000, 1'b1, 8'(8'h61 + i));
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        check_output("io_full_at_5",  32'(bus.io_buffer_full), 32'h0);
        check_output("tx_valid_fill", 32'(bus.tx_valid),       32'h1);
        check_output("tx_head_fill",  32'(bus.tx_data),        32'h61);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h66);
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        check_output("io_full_at_6", 32'(bus.io_buffer_full), 32'h1);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h00);
        apply_stimulus(32'h0003_0001, 1'b1, 8'h55);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h67);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h68);
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        check_output("no_overflow_at_8", 32'(tx_overflow), 32'h0);
        apply_stimulus(32'h0003_0000, 1'b1, 8'h69);
        apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        check_output("overflow_at_9", 32'(tx_overflow), 32'h1);

        // TX drain: exactly the eight accepted bytes, in order
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_output("drain_valid", 32'(bus.tx_valid), 32'h1);
            check_output("drain_data",  32'(bus.tx_data),  32'(8'h61 + i));
            apply_stimulus(IDLE_ADDR, 1'b0, 8'h00);
        end
        check_output("drained_valid",    32'(bus.tx_valid),       32'h0);
        check_output("drained_data",     32'(bus.tx_data),        32'h00);
        check_output("drained_io_full",  32'(bus.io_buffer_full), 32'h0);
        check_output("overflow_sticky",  32'(tx_overflow),        32'h1);
        bus.tx_ready = 1'b0;

        // Program stop
        apply_stimulus(32'h0003_0004, 1'b1, 8'h55);
        check_output("program_stop", 32'(program_stop), 32'h1);
        check_output("stop_tx_valid", 32'(bus.tx_valid), 32'h1);
        check_output("stop_tx_data",  32'(bus.tx_data),  32'h00);

        // Asynchronous reset while a read is in flight
        apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
        check_output("pre_rst_read", 32'(bus.cpu_din), 32'hA5);
        bus.cpu_a = 32'h0001_FFFF;
        #3 rst_in = 1'b0;
        #1;
        check_output("arst_cpu_din",      32'(bus.cpu_din),        32'h00);
        check_output("arst_program_stop", 32'(program_stop),       32'h0);
        check_output("arst_tx_overflow",  32'(tx_overflow),        32'h0);
        check_output("arst_tx_valid",     32'(bus.tx_valid),       32'h0);
        check_output("arst_tx_data",      32'(bus.tx_data),        32'h00);
        check_output("arst_rx_ready",     32'(bus.rx_ready),       32'h0);
        check_output("arst_io_full",      32'(bus.io_buffer_full), 32'h0);
        step();
        check_output("arst_no_read_data", 32'(bus.cpu_din), 32'h00);
        rst_in = 1'b1;
        apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
        check_output("ram_kept_0x10", 32'(bus.cpu_din), 32'hA5);
        apply_stimulus(32'h0001_FFFF, 1'b0, 8'h00);
        check_output("ram_kept_top", 32'(bus.cpu_din), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
